// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pc_fetch_ctrl
// Brief   : Single-outstanding instruction fetch FSM with redirect/kill.
//           Optional macro PC_MISALIGN_TRAP_EN traps misaligned redirects.
// Rev     : 1.0
// ============================================================================
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h00000000,
  parameter int          COUNT_W      = 32
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [31:0]        imem_rdata,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_target,
  output logic               instr_valid,
  output logic [31:0]        instr,
  output logic [31:0]        instr_pc,
  input  logic               instr_ready,
  output logic               fault,
  output logic [COUNT_W-1:0] fetch_count
);

  localparam logic [2:0] S_BOOT  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
`ifdef PC_MISALIGN_TRAP_EN
  localparam logic [2:0] S_FAULT = 3'd4;
`endif

  logic [2:0]         state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        instr_q, instr_d;
  logic [31:0]        instr_pc_q, instr_pc_d;
  logic               kill_q, kill_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [31:0]        w_target;

`ifdef PC_MISALIGN_TRAP_EN
  logic fault_q, fault_d;
  assign w_target = redirect_target;
  assign fault    = fault_q;
`else
  logic [1:0] w_unused_tgt_lsb;
  assign w_unused_tgt_lsb = redirect_target[1:0];
  assign w_target         = {redirect_target[31:2], 2'b00};
  assign fault            = 1'b0;
`endif

  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == S_HOLD);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign fetch_count = count_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    count_d    = count_q;
`ifdef PC_MISALIGN_TRAP_EN
    fault_d    = fault_q;
`endif
    case (state_q)
      S_BOOT: state_d = S_REQ;
      S_REQ: begin
        // Address may only move before the grant; a granted redirect kills the reply.
        if (redirect_valid) pc_d = w_target;
        if (imem_gnt) begin
          state_d = S_WAIT;
          kill_d  = redirect_valid;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_d = w_target;
          if (imem_rvalid) begin
            state_d = S_REQ;
            kill_d  = 1'b0;
          end else begin
            kill_d  = 1'b1;
          end
        end else if (imem_rvalid) begin
          kill_d  = 1'b0;
          state_d = S_REQ;
          if (!kill_q) begin
            instr_d    = imem_rdata;
            instr_pc_d = pc_q;
            pc_d       = pc_q + 32'd4;
            state_d    = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_d    = w_target;
          state_d = S_REQ;
        end else if (instr_ready) begin
          count_d = count_q + COUNT_W'(1);
          state_d = S_REQ;
        end
      end
      default: ;
    endcase
`ifdef PC_MISALIGN_TRAP_EN
    if (redirect_valid && (|redirect_target[1:0]) &&
        (state_q == S_REQ || state_q == S_WAIT || state_q == S_HOLD)) begin
      state_d = S_FAULT;
      fault_d = 1'b1;
      pc_d    = pc_q;
      kill_d  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_VECTOR;
      kill_q     <= 1'b0;
      instr_q    <= 32'd0;
      instr_pc_q <= 32'd0;
      count_q    <= '0;
`ifdef PC_MISALIGN_TRAP_EN
      fault_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      count_q    <= count_d;
`ifdef PC_MISALIGN_TRAP_EN
      fault_q    <= fault_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pc_fetch_ctrl
// Brief   : Self-checking bench for pc_fetch_ctrl (directed + random vs model).
// Rev     : 1.0
// ============================================================================
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req, imem_gnt = 0, imem_rvalid = 0;
  logic [31:0] imem_addr, imem_rdata = 0;
  logic        redirect_valid = 0;
  logic [31:0] redirect_target = 0;
  logic        instr_valid, instr_ready = 0, fault;
  logic [31:0] instr, instr_pc, fetch_count;

  int n_checks = 0;
  int n_fail   = 0;

  pc_fetch_ctrl dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .fault(fault), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Reference: which phase of the fetch transaction we are in, as flags.
  bit          m_boot, m_req, m_wait, m_hold, m_trap, m_kill, m_fault;
  logic [31:0] m_pc, m_instr, m_ipc, m_cnt;

  function automatic logic [130:0] dut_vec();
    return {imem_req, imem_addr, instr_valid, instr, instr_pc, fault, fetch_count};
  endfunction

  function automatic logic [130:0] model_vec();
    return {m_req, m_pc, m_hold, m_instr, m_ipc, m_fault, m_cnt};
  endfunction

  task automatic model_reset();
    m_boot = 1; m_req = 0; m_wait = 0; m_hold = 0; m_trap = 0; m_kill = 0;
    m_fault = 0; m_pc = 32'h0; m_instr = 0; m_ipc = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input bit g, input bit rv, input logic [31:0] rd,
                            input bit red, input logic [31:0] t_in, input bit rdy);
    logic [31:0] t;
    bit bad;
    bad = 0;
`ifdef PC_MISALIGN_TRAP_EN
    t   = t_in;
    bad = (t_in % 4) != 0;
`else
    t   = t_in - (t_in % 4);
`endif
    if (m_boot) begin
      m_boot = 0; m_req = 1;
    end else if (m_trap) begin
    end else if (red && bad) begin
      m_req = 0; m_wait = 0; m_hold = 0; m_kill = 0; m_trap = 1; m_fault = 1;
    end else if (m_req) begin
      if (red) m_pc = t;
      if (g) begin m_req = 0; m_wait = 1; m_kill = red; end
    end else if (m_wait) begin
      if (red) begin
        m_pc = t;
        if (rv) begin m_wait = 0; m_req = 1; m_kill = 0; end
        else m_kill = 1;
      end else if (rv) begin
        m_wait = 0;
        if (m_kill) begin m_kill = 0; m_req = 1; end
        else begin m_instr = rd; m_ipc = m_pc; m_pc = m_pc + 4; m_hold = 1; end
      end
    end else if (m_hold) begin
      if (red) begin m_pc = t; m_hold = 0; m_req = 1; end
      else if (rdy) begin m_cnt = m_cnt + 1; m_hold = 0; m_req = 1; end
    end
  endtask

  task automatic cycle(input bit g, input bit rv, input logic [31:0] rd,
                       input bit red, input logic [31:0] t, input bit rdy);
    imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
    redirect_valid = red; redirect_target = t; instr_ready = rdy;
    model_edge(g, rv, rd, red, t, rdy);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 0;
    imem_gnt = 0; imem_rvalid = 0; redirect_valid = 0; instr_ready = 0;
    model_reset();
    @(posedge clk); @(negedge clk);
    reset = 1;
  endtask

  task automatic test_reset();
    reset = 0;
    model_reset();
    #2;
    n_checks++;
    if (dut_vec() !== 131'd0) begin
      n_fail++; $display("FAIL reset_outputs got=%h want=%h", dut_vec(), 131'd0);
    end
    @(posedge clk); @(negedge clk);
    reset = 1;
  endtask

  task automatic test_basic_fetch();
    logic [31:0] d;
    cycle(1, 1, 32'hA5A5A5A5, 0, 0, 1);  // BOOT: rvalid must be ignored
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL boot_to_req req=%b addr=%h iv=%b want 1/0/0", imem_req, imem_addr, instr_valid);
    end
    for (int k = 0; k < 3; k++) begin
      d = $urandom;
      cycle(1, 1, d, 0, 0, 1);
      n_checks++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
        n_fail++; $display("FAIL basic_wait[%0d] req=%b iv=%b want 0/0", k, imem_req, instr_valid);
      end
      cycle(1, 1, d, 0, 0, 1);
      n_checks++;
      if (instr_valid !== 1'b1 || instr !== d || instr_pc !== 32'(4*k)) begin
        n_fail++; $display("FAIL basic_hold[%0d] iv=%b instr=%h pc=%h want 1/%h/%h", k, instr_valid, instr, instr_pc, d, 4*k);
      end
      cycle(1, 1, d, 0, 0, 1);
      n_checks++;
      if (fetch_count !== 32'(k+1) || imem_req !== 1'b1 || imem_addr !== 32'(4*(k+1))) begin
        n_fail++; $display("FAIL basic_accept[%0d] cnt=%0d req=%b addr=%h want %0d/1/%h", k, fetch_count, imem_req, imem_addr, k+1, 4*(k+1));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d, c, p;
    d = $urandom;
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, d, 0, 0, 0);
    c = m_cnt; p = m_ipc;
    for (int k = 0; k < 5; k++) begin
      cycle(1, 1, $urandom, 0, 0, 0);
      n_checks++;
      if (instr_valid !== 1'b1 || instr !== d || instr_pc !== p || imem_req !== 1'b0 || fetch_count !== c) begin
        n_fail++; $display("FAIL backpressure[%0d] iv=%b instr=%h ipc=%h req=%b cnt=%0d want 1/%h/%h/0/%0d", k, instr_valid, instr, instr_pc, imem_req, fetch_count, d, p, c);
      end
    end
    cycle(0, 0, 0, 0, 0, 1);
    n_checks++;
    if (fetch_count !== c + 1 || instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL backpressure_accept cnt=%0d iv=%b want %0d/0", fetch_count, instr_valid, c+1);
    end
  endtask

  task automatic test_kill();
    logic [31:0] old;
    old = m_instr;
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 32'h100, 0);
    cycle(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL kill_wait req=%b iv=%b want 0/0", imem_req, instr_valid);
    end
    cycle(0, 1, 32'hDEADBEEF, 0, 0, 0);
    n_checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100 || instr !== old) begin
      n_fail++; $display("FAIL kill_discard iv=%b req=%b addr=%h instr=%h want 0/1/100/%h", instr_valid, imem_req, imem_addr, instr, old);
    end
  endtask

  task automatic test_redirect_vs_accept();
    logic [31:0] c;
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, $urandom, 0, 0, 0);
    c = m_cnt;
    cycle(0, 0, 0, 1, 32'h40, 1);
    n_checks++;
    if (fetch_count !== c || imem_addr !== 32'h40 || instr_valid !== 1'b0 || imem_req !== 1'b1) begin
      n_fail++; $display("FAIL redirect_vs_accept cnt=%0d addr=%h iv=%b req=%b want %0d/40/0/1", fetch_count, imem_addr, instr_valid, imem_req, c);
    end
  endtask

  task automatic test_misalign();
    cycle(0, 0, 0, 1, 32'h102, 0);
`ifdef PC_MISALIGN_TRAP_EN
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (fault !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
        n_fail++; $display("FAIL misalign_trap[%0d] fault=%b req=%b iv=%b want 1/0/0", k, fault, imem_req, instr_valid);
      end
      cycle(1, 1, $urandom, 1, 32'h200, 1);
    end
    do_reset();
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 32'h40, 0);
`else
    n_checks++;
    if (imem_addr !== 32'h100 || imem_req !== 1'b1 || fault !== 1'b0) begin
      n_fail++; $display("FAIL misalign_force addr=%h req=%b fault=%b want 100/1/0", imem_addr, imem_req, fault);
    end
`endif
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    d = $urandom;
    cycle(0, 0, 0, 1, 32'hFFFFFFFC, 0);
    n_checks++;
    if (imem_addr !== 32'hFFFFFFFC) begin
      n_fail++; $display("FAIL wrap_redirect addr=%h want fffffffc", imem_addr);
    end
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, d, 0, 0, 0);
    n_checks++;
    if (imem_addr !== 32'h0 || instr_pc !== 32'hFFFFFFFC || instr !== d) begin
      n_fail++; $display("FAIL wrap_pc addr=%h ipc=%h instr=%h want 0/fffffffc/%h", imem_addr, instr_pc, instr, d);
    end
    cycle(0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_reset_in_wait();
    cycle(1, 0, 0, 0, 0, 0);
    n_checks++;
    if (imem_req !== 1'b0 || fetch_count === 32'h0) begin
      n_fail++; $display("FAIL pre_reset_wait req=%b cnt=%0d want 0/nonzero", imem_req, fetch_count);
    end
    reset = 0;
    model_reset();
    #1;
    n_checks++;
    if (dut_vec() !== 131'd0) begin
      n_fail++; $display("FAIL async_reset got=%h want=%h", dut_vec(), 131'd0);
    end
    imem_rvalid = 1; imem_rdata = 32'h12345678;
    @(posedge clk); @(negedge clk);
    reset = 1;
    cycle(0, 1, 32'h12345678, 0, 0, 1);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0 || instr !== 32'h0) begin
      n_fail++; $display("FAIL post_reset_boot req=%b addr=%h iv=%b instr=%h want 1/0/0/0", imem_req, imem_addr, instr_valid, instr);
    end
  endtask

  task automatic test_random();
    logic [31:0] t;
    for (int k = 0; k < 3000; k++) begin
      t = $urandom;
`ifdef PC_MISALIGN_TRAP_EN
      if ($urandom_range(0, 31) != 0) t = t & 32'hFFFFFFFC;
`endif
      cycle($urandom_range(0, 1), $urandom_range(0, 1), $urandom,
            $urandom_range(0, 7) == 0, t, $urandom_range(0, 1));
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++; $display("FAIL random[%0d] got=%h want=%h", k, dut_vec(), model_vec());
      end
      if (m_trap && $urandom_range(0, 7) == 0) do_reset();
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic_fetch();
    test_backpressure();
    test_kill();
    test_redirect_vs_accept();
    test_misalign();
    test_wrap();
    test_reset_in_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
